ddr3_ref_arb: RTL and testbench
===============================

Name: ddr3_ref_arb

Overview:
- Responder for the configurator's controller-side command interface (req/run/rdy/cmd/ref/ba/adr).
- During initialisation it passes configurator commands straight through to the DDL command port.
- Once the configurator asserts run, it:
  - tracks refresh debt from the configurator's refresh ticks;
  - issues PRECHARGE-ALL + REFRESH sequences;
  - arbitrates those sequences against a user (AXI FSM) command port.
- Sits between ddr3_cfg, the AXI front-end FSM and ddr3_ddl.

Parameters:
- DDR_ROW_BITS, 13, address width; RSB = DDR_ROW_BITS-1.
- REF_URGENT, 4, debt level at which refresh preempts user traffic (1..8).
- REF_MAX, 8, debt saturation limit; the DDR3 postponement limit.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_req_i  in  1  configurator command request.
- cfg_rdy_o  out  1  configurator command accepted.
- cfg_run_i  in  1  initialisation complete; level signal.
- cfg_ref_i  in  1  refresh-interval tick; 1-cycle pulse.
- cfg_cmd_i  in  3  configurator command.
- cfg_ba_i  in  3  configurator bank.
- cfg_adr_i  in  DDR_ROW_BITS  configurator address.
- usr_req_i  in  1  user command request.
- usr_rdy_o  out  1  user command accepted.
- usr_cmd_i  in  3  user command.
- usr_ba_i  in  3  user bank.
- usr_adr_i  in  DDR_ROW_BITS  user address.
- usr_hold_o  out  1  refresh pending; user must finish its burst and stop issuing.
- ddl_req_o  out  1  command request to DDL.
- ddl_rdy_i  in  1  DDL accepted command.
- ddl_cmd_o  out  3  command to DDL.
- ddl_ba_o  out  3  bank to DDL.
- ddl_adr_o  out  DDR_ROW_BITS  address to DDL.
- ref_debt_o  out  4  outstanding refresh count.
- ref_ovf_o  out  1  sticky: a tick arrived while debt = REF_MAX.

Behaviour:
- Command encodings are the shared CMD_NOOP / CMD_PREC / CMD_REFR values from ddr3_settings.vh.
- Reset values: state=INIT; debt=0; ref_ovf_o=0; usr_rdy_o=0; usr_hold_o=0; registered ddl_req=0, ddl_cmd=CMD_NOOP, ddl_ba=0, ddl_adr=0.
- INIT (cfg_run_i=0):
  - Combinational pass-through: ddl_req_o=cfg_req_i, ddl_cmd_o/ba/adr = cfg_*, cfg_rdy_o=ddl_rdy_i.
  - usr_rdy_o=0. cfg_ref_i ignored; debt held at 0.
- INIT -> IDLE on the first cycle with cfg_run_i=1. From then on, outputs come from registers and cfg_rdy_o=0.
- cfg_run_i falling while running: return to INIT on the next edge, debt cleared, but only after any in-flight ddl handshake completes.
- Debt counter, 4 bits:
  - +1 on cfg_ref_i.
  - -1 on ddl_rdy_i while ddl_cmd_o=CMD_REFR and ddl_req_o=1.
  - Both in the same cycle: debt unchanged.
  - Saturates at REF_MAX; a tick at saturation sets ref_ovf_o, which clears only on reset.
- IDLE priority, evaluated each cycle:
  1. debt>=REF_URGENT, or (debt>0 and usr_req_i=0) -> PREA.
  2. usr_req_i=1 -> USER.
- PREA:
  - Drive ddl_req_o=1, cmd=CMD_PREC, adr[10]=1, other adr bits 0, ba=0.
  - Hold all fields stable until ddl_rdy_i, then -> REFR.
- REFR:
  - Drive ddl_req_o=1, cmd=CMD_REFR, adr=0, ba=0; hold until ddl_rdy_i.
  - On acceptance, debt decrements.
  - If debt after the decrement is >0 and usr_req_i=0, go to REFR again (no second PREA); otherwise -> IDLE.
- USER:
  - Register usr_cmd/ba/adr on entry and drive ddl_req_o=1 until ddl_rdy_i.
  - usr_rdy_o pulses for exactly the ddl_rdy_i cycle; then -> IDLE.
  - Latency: usr_req_i seen at edge N -> ddl_req_o high after edge N+1.
- usr_hold_o = (debt>=REF_URGENT) while running; registered; user commands already in flight still complete.
- ddl_req_o never drops before ddl_rdy_i, and fields never change while it is high.

Test Plan:
- Init pass-through: cfg_run_i=0, cfg_req_i=1 with cmd=MRS, ba=2, adr=0x0520 -> ddl_* match the same cycle; cfg_rdy_o mirrors a ddl_rdy_i pulse; usr_req_i=1 never sees usr_rdy_o.
- Opportunistic refresh: run=1, one cfg_ref_i, user idle -> PREC with adr[10]=1, then REFR; debt 1 -> 0; ddl_rdy_i stalled 3 cycles holds fields stable.
- Urgent preemption: user streaming, 4 ticks -> usr_hold_o=1; the current user command completes, then PREA, then 4 back-to-back REFR; debt reaches 0 and hold drops.
- Tick coincident with REFR acceptance at debt=2 -> debt stays 2.
- Overflow: 9 ticks with ddl_rdy_i held low -> debt=8, ref_ovf_o=1 and sticky.
- Reset mid-REFR (ddl_req_o=1, debt=3) -> next cycle ddl_req_o=0, debt=0, state INIT.

Source files
------------

// File: rtl/ddr3_ref_arb.sv
// Refresh-debt tracker and DDL command arbiter. During initialisation the
// configurator drives the DDL directly; once running, refresh bursts and user commands share the port.
module ddr3_ref_arb #(
  parameter int         DDR_ROW_BITS = 13,
  parameter int         REF_URGENT   = 4,
  parameter int         REF_MAX      = 8,
  parameter logic [2:0] CMD_NOOP     = 3'b111,
  parameter logic [2:0] CMD_PREC     = 3'b010,
  parameter logic [2:0] CMD_REFR     = 3'b001
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_req_i,
  output logic                    cfg_rdy_o,
  input  logic                    cfg_run_i,
  input  logic                    cfg_ref_i,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  input  logic                    usr_req_i,
  output logic                    usr_rdy_o,
  input  logic [2:0]              usr_cmd_i,
  input  logic [2:0]              usr_ba_i,
  input  logic [DDR_ROW_BITS-1:0] usr_adr_i,
  output logic                    usr_hold_o,
  output logic                    ddl_req_o,
  input  logic                    ddl_rdy_i,
  output logic [2:0]              ddl_cmd_o,
  output logic [2:0]              ddl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
  output logic [3:0]              ref_debt_o,
  output logic                    ref_ovf_o
);

  localparam int RSB = DDR_ROW_BITS - 1;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_PREA = 3'd2;
  localparam logic [2:0] S_REFR = 3'd3;
  localparam logic [2:0] S_USER = 3'd4;

  localparam logic [3:0]   DEBT_MAX = 4'(REF_MAX);
  localparam logic [3:0]   DEBT_URG = 4'(REF_URGENT);
  // PRECHARGE-ALL is selected by A10 high.
  localparam logic [RSB:0] ADR_PREA = DDR_ROW_BITS'(11'h400);

  logic [2:0]   r_state;
  logic [3:0]   r_debt;
  logic         r_ovf;
  logic         r_hold;
  logic         r_req;
  logic [2:0]   r_cmd;
  logic [2:0]   r_ba;
  logic [RSB:0] r_adr;

  logic         w_init;
  logic         w_inc;
  logic         w_dec;
  logic         w_ovf_set;
  logic [3:0]   w_debt_nxt;
  logic         w_stop;

  assign w_init = (r_state == S_INIT);
  assign w_inc  = cfg_ref_i && !w_init;
  assign w_dec  = r_req && ddl_rdy_i && (r_cmd == CMD_REFR) && (r_debt != 4'd0);
  // A falling run waits for any outstanding handshake before leaving.
  assign w_stop = !cfg_run_i && (!r_req || ddl_rdy_i);

  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_set  = 1'b0;
    if (w_inc && !w_dec) begin
      if (r_debt == DEBT_MAX) w_ovf_set  = 1'b1;
      else                    w_debt_nxt = r_debt + 4'd1;
    end else if (w_dec && !w_inc) begin
      w_debt_nxt = r_debt - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
      r_debt  <= 4'd0;
      r_ovf   <= 1'b0;
      r_hold  <= 1'b0;
      r_req   <= 1'b0;
      r_cmd   <= CMD_NOOP;
      r_ba    <= 3'd0;
      r_adr   <= '0;
    end else if (w_init) begin
      r_debt <= 4'd0;
      r_hold <= 1'b0;
      if (cfg_run_i) r_state <= S_IDLE;
    end else if (w_stop) begin
      r_state <= S_INIT;
      r_debt  <= 4'd0;
      r_hold  <= 1'b0;
      r_req   <= 1'b0;
      r_cmd   <= CMD_NOOP;
      r_ba    <= 3'd0;
      r_adr   <= '0;
    end else begin
      r_debt <= w_debt_nxt;
      r_ovf  <= r_ovf | w_ovf_set;
      r_hold <= (w_debt_nxt >= DEBT_URG);
      case (r_state)
        S_IDLE: begin
          if ((r_debt >= DEBT_URG) || ((r_debt != 4'd0) && !usr_req_i)) r_state <= S_PREA;
          else if (usr_req_i)                                            r_state <= S_USER;
        end
        S_PREA: begin
          if (!r_req) begin
            r_req <= 1'b1;
            r_cmd <= CMD_PREC;
            r_ba  <= 3'd0;
            r_adr <= ADR_PREA;
          end else if (ddl_rdy_i) begin
            r_req   <= 1'b0;
            r_state <= S_REFR;
          end
        end
        S_REFR: begin
          if (!r_req) begin
            r_req <= 1'b1;
            r_cmd <= CMD_REFR;
            r_ba  <= 3'd0;
            r_adr <= '0;
          end else if (ddl_rdy_i) begin
            r_req   <= 1'b0;
            // Banks stay precharged, so further refreshes skip the PREA.
            r_state <= ((w_debt_nxt != 4'd0) && !usr_req_i) ? S_REFR : S_IDLE;
          end
        end
        S_USER: begin
          if (!r_req) begin
            r_req <= 1'b1;
            r_cmd <= usr_cmd_i;
            r_ba  <= usr_ba_i;
            r_adr <= usr_adr_i;
          end else if (ddl_rdy_i) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign ddl_req_o  = w_init ? cfg_req_i : r_req;
  assign ddl_cmd_o  = w_init ? cfg_cmd_i : r_cmd;
  assign ddl_ba_o   = w_init ? cfg_ba_i  : r_ba;
  assign ddl_adr_o  = w_init ? cfg_adr_i : r_adr;
  assign cfg_rdy_o  = w_init & ddl_rdy_i;
  assign usr_rdy_o  = (r_state == S_USER) & r_req & ddl_rdy_i;
  assign usr_hold_o = r_hold;
  assign ref_debt_o = r_debt;
  assign ref_ovf_o  = r_ovf;

endmodule

// File: tb/tb_ddr3_ref_arb.sv
// Scoreboard bench for ddr3_ref_arb: expected DDL commands are queued as
// stimulus is driven and compared as each DDL handshake completes.
module tb_ddr3_ref_arb;

  localparam logic [2:0] C_MRS  = 3'b000;
  localparam logic [2:0] C_REFR = 3'b001;
  localparam logic [2:0] C_PREC = 3'b010;
  localparam logic [2:0] C_WR   = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_req_i, cfg_run_i, cfg_ref_i;
  logic [2:0]  cfg_cmd_i, cfg_ba_i;
  logic [12:0] cfg_adr_i;
  logic        cfg_rdy_o;
  logic        usr_req_i;
  logic [2:0]  usr_cmd_i, usr_ba_i;
  logic [12:0] usr_adr_i;
  logic        usr_rdy_o, usr_hold_o;
  logic        ddl_req_o, ddl_rdy_i;
  logic [2:0]  ddl_cmd_o, ddl_ba_o;
  logic [12:0] ddl_adr_o;
  logic [3:0]  ref_debt_o;
  logic        ref_ovf_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [18:0] sb_q[$];
  logic        sb_on = 1'b0;
  logic        p_req = 1'b0;
  logic        p_acc = 1'b0;
  logic [18:0] p_fld = '0;

  ddr3_ref_arb dut (
    .clock(clock), .reset(reset),
    .cfg_req_i(cfg_req_i), .cfg_rdy_o(cfg_rdy_o), .cfg_run_i(cfg_run_i),
    .cfg_ref_i(cfg_ref_i), .cfg_cmd_i(cfg_cmd_i), .cfg_ba_i(cfg_ba_i),
    .cfg_adr_i(cfg_adr_i),
    .usr_req_i(usr_req_i), .usr_rdy_o(usr_rdy_o), .usr_cmd_i(usr_cmd_i),
    .usr_ba_i(usr_ba_i), .usr_adr_i(usr_adr_i), .usr_hold_o(usr_hold_o),
    .ddl_req_o(ddl_req_o), .ddl_rdy_i(ddl_rdy_i), .ddl_cmd_o(ddl_cmd_o),
    .ddl_ba_o(ddl_ba_o), .ddl_adr_o(ddl_adr_o),
    .ref_debt_o(ref_debt_o), .ref_ovf_o(ref_ovf_o)
  );

  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a);
    sb_q.push_back({c, b, a});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Wait for a request, stall it, then accept it for one cycle.
  task automatic serve(input int stall, input logic exp_usr_rdy, input logic tick_on_acc);
    int cnt;
    cnt = 0;
    @(negedge clock);
    while (!ddl_req_o && cnt < 60) begin
      @(negedge clock);
      cnt++;
    end
    chk_eq("req_seen", 32'(ddl_req_o), 1);
    repeat (stall) @(negedge clock);
    step();
    ddl_rdy_i = 1'b1;
    cfg_ref_i = tick_on_acc;
    @(negedge clock);
    chk_eq("usr_rdy_pulse", 32'(usr_rdy_o), 32'(exp_usr_rdy));
    step();
    ddl_rdy_i = 1'b0;
    cfg_ref_i = 1'b0;
  endtask

  // DDL-side monitor: ordering, stability while stalled, no early drop.
  always @(negedge clock) begin
    if (sb_on) begin
      if (p_req && !p_acc) begin
        chk_eq("req_held", 32'(ddl_req_o), 1);
        chk_eq("fields_stable", 32'({ddl_cmd_o, ddl_ba_o, ddl_adr_o}), 32'(p_fld));
      end
      if (ddl_req_o && ddl_rdy_i) begin
        if (sb_q.size() == 0) chk_eq("sb_extra_cmd", 32'(sb_q.size()), 1);
        else chk_eq("ddl_cmd", 32'({ddl_cmd_o, ddl_ba_o, ddl_adr_o}), 32'(sb_q.pop_front()));
      end
      p_req <= ddl_req_o;
      p_acc <= ddl_rdy_i;
      p_fld <= {ddl_cmd_o, ddl_ba_o, ddl_adr_o};
    end else begin
      p_req <= 1'b0;
      p_acc <= 1'b0;
    end
  end

  initial begin
    int cnt;
    reset = 1'b1;
    cfg_req_i = 0; cfg_run_i = 0; cfg_ref_i = 0;
    cfg_cmd_i = '0; cfg_ba_i = '0; cfg_adr_i = '0;
    usr_req_i = 0; usr_cmd_i = '0; usr_ba_i = '0; usr_adr_i = '0;
    ddl_rdy_i = 0;
    step();
    step();
    @(negedge clock);
    chk_eq("rst_debt", 32'(ref_debt_o), 0);
    chk_eq("rst_ovf", 32'(ref_ovf_o), 0);
    chk_eq("rst_hold", 32'(usr_hold_o), 0);
    chk_eq("rst_usr_rdy", 32'(usr_rdy_o), 0);
    chk_eq("rst_ddl_req", 32'(ddl_req_o), 0);
    step();
    reset = 1'b0;

    // Initialisation pass-through
    cfg_req_i = 1; cfg_cmd_i = C_MRS; cfg_ba_i = 3'd2; cfg_adr_i = 13'h0520;
    usr_req_i = 1; usr_cmd_i = C_WR;
    @(negedge clock);
    chk_eq("init_pass", 32'({ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o}), 32'({1'b1, C_MRS, 3'd2, 13'h0520}));
    chk_eq("init_cfg_rdy_lo", 32'(cfg_rdy_o), 0);
    step();
    ddl_rdy_i = 1; cfg_ref_i = 1;
    @(negedge clock);
    chk_eq("init_cfg_rdy_hi", 32'(cfg_rdy_o), 1);
    chk_eq("init_usr_rdy", 32'(usr_rdy_o), 0);
    step();
    ddl_rdy_i = 0; cfg_ref_i = 0; cfg_req_i = 0; usr_req_i = 0;
    @(negedge clock);
    chk_eq("init_debt_ignored", 32'(ref_debt_o), 0);
    chk_eq("init_cfg_rdy_drop", 32'(cfg_rdy_o), 0);

    // Enter run mode; outputs become registered
    step();
    cfg_run_i = 1;
    step();
    ddl_rdy_i = 1;
    @(negedge clock);
    chk_eq("run_ddl_req", 32'(ddl_req_o), 0);
    chk_eq("run_cfg_rdy", 32'(cfg_rdy_o), 0);
    step();
    ddl_rdy_i = 0;
    sb_on = 1;

    // Opportunistic refresh with a stalled PREA
    push(C_PREC, 3'd0, 13'h0400);
    push(C_REFR, 3'd0, 13'h0000);
    cfg_ref_i = 1;
    step();
    cfg_ref_i = 0;
    @(negedge clock);
    chk_eq("opp_debt1", 32'(ref_debt_o), 1);
    serve(3, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    @(negedge clock);
    chk_eq("opp_debt0", 32'(ref_debt_o), 0);

    // User streaming, then urgent preemption
    step();
    usr_req_i = 1;
    for (int k = 1; k <= 2; k++) begin
      usr_cmd_i = C_WR; usr_ba_i = 3'(k); usr_adr_i = 13'(k * 16);
      push(C_WR, 3'(k), 13'(k * 16));
      serve(0, 1'b1, 1'b0);
    end
    usr_ba_i = 3'd5; usr_adr_i = 13'h0123;
    push(C_WR, 3'd5, 13'h0123);
    push(C_PREC, 3'd0, 13'h0400);
    repeat (4) push(C_REFR, 3'd0, 13'h0000);
    cfg_ref_i = 1;
    repeat (4) @(posedge clock);
    #1;
    cfg_ref_i = 0; usr_req_i = 0;
    @(negedge clock);
    chk_eq("urg_hold", 32'(usr_hold_o), 1);
    chk_eq("urg_debt4", 32'(ref_debt_o), 4);
    chk_eq("urg_user_inflight", 32'(ddl_req_o), 1);
    serve(0, 1'b1, 1'b0);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    @(negedge clock);
    chk_eq("urg_hold_drop", 32'(usr_hold_o), 0);
    repeat (3) serve(0, 1'b0, 1'b0);
    @(negedge clock);
    chk_eq("urg_debt0", 32'(ref_debt_o), 0);
    chk_eq("urg_hold_end", 32'(usr_hold_o), 0);

    // Tick coincident with a REFR acceptance
    step();
    push(C_PREC, 3'd0, 13'h0400);
    repeat (3) push(C_REFR, 3'd0, 13'h0000);
    cfg_ref_i = 1;
    repeat (2) @(posedge clock);
    #1;
    cfg_ref_i = 0;
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b1);
    @(negedge clock);
    chk_eq("coinc_debt2", 32'(ref_debt_o), 2);
    serve(0, 1'b0, 1'b0);
    serve(0, 1'b0, 1'b0);
    @(negedge clock);
    chk_eq("coinc_debt0", 32'(ref_debt_o), 0);

    // Overflow with the DDL stalled
    step();
    cfg_ref_i = 1;
    repeat (9) @(posedge clock);
    #1;
    cfg_ref_i = 0;
    @(negedge clock);
    chk_eq("ovf_debt8", 32'(ref_debt_o), 8);
    chk_eq("ovf_flag", 32'(ref_ovf_o), 1);
    chk_eq("ovf_hold", 32'(usr_hold_o), 1);
    repeat (3) step();
    @(negedge clock);
    chk_eq("ovf_sticky", 32'(ref_ovf_o), 1);
    push(C_PREC, 3'd0, 13'h0400);
    repeat (5) push(C_REFR, 3'd0, 13'h0000);
    serve(0, 1'b0, 1'b0);
    repeat (5) serve(0, 1'b0, 1'b0);
    cnt = 0;
    @(negedge clock);
    while (!ddl_req_o && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    chk_eq("mid_refr_req", 32'(ddl_req_o), 1);
    chk_eq("mid_refr_debt3", 32'(ref_debt_o), 3);
    chk_eq("ovf_sticky2", 32'(ref_ovf_o), 1);
    chk_eq("sb_drained", 32'(sb_q.size()), 0);
    sb_on = 0;

    // Reset in the middle of a REFR request
    step();
    reset = 1;
    step();
    reset = 0; cfg_run_i = 0; ddl_rdy_i = 1;
    @(negedge clock);
    chk_eq("rst_mid_req", 32'(ddl_req_o), 0);
    chk_eq("rst_mid_debt", 32'(ref_debt_o), 0);
    chk_eq("rst_mid_ovf", 32'(ref_ovf_o), 0);
    chk_eq("rst_mid_init", 32'(cfg_rdy_o), 1);
    step();
    ddl_rdy_i = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
